// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding / hazard controller: mux select
// encoding, the zero-register index and the controller FSM states.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    HOLD     = 2'b10
  } fwd_state_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Priority compare for one EX operand: the newest in-flight producer (MEM)
// beats the older one (WB); writes to x0 are never forwarded.
module fwd_sel_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);

  fwd_sel_t sel_c;

  always_comb begin
    sel_c = FWD_RF;
    if (mem_we && (mem_rd != REG_AW'(REG_ZERO)) && (mem_rd == rs)) begin
      sel_c = FWD_MEM;
    end else if (wb_we && (wb_rd != REG_AW'(REG_ZERO)) && (wb_rd == rs)) begin
      sel_c = FWD_WB;
    end
  end

  assign sel = sel_c;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-mux select and load-use / memory-busy hazard control for the EX stage.
// Optional build macro FWD_HAZARD_PERF_EN adds saturating 32-bit perf counters.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              hold_o
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_lu_stall_o,
  output logic [31:0]       perf_fwd_o,
  output logic [31:0]       perf_hold_o
`endif
);

  if (NUM_REGS > (1 << REG_AW)) begin : g_bad_cfg
    $error("NUM_REGS does not fit in REG_AW address bits");
  end

  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              ex_we, ex_ld, mem_we, wb_we;
  logic              lu, hold, stall, capture;
  fwd_state_t        state_q, state_d;

  assign hold = mem_busy_i;

  assign lu = ex_ld && ex_we && (ex_rd != RZ) && id_valid_i &&
              ((id_use_rs1_i && (id_rs1_i == ex_rd)) ||
               (id_use_rs2_i && (id_rs2_i == ex_rd)));

  // The inserted bubble moves the load to MEM, so a stall can never repeat back-to-back.
  assign stall   = lu && !hold && !flush_i && (state_q != LU_STALL);
  assign capture = id_valid_i && !flush_i && !stall;

  assign stall_o  = stall;
  assign bubble_o = stall;
  assign hold_o   = hold;

  fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_a (
    .rs     (ex_rs1),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .wb_rd  (wb_rd),
    .wb_we  (wb_we),
    .sel    (fwd_a_o)
  );

  fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_b (
    .rs     (ex_rs2),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .wb_rd  (wb_rd),
    .wb_we  (wb_we),
    .sel    (fwd_b_o)
  );

  // Shadow scoreboard: ID -> EX -> MEM -> WB, frozen while memory is busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd  <= '0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_rd  <= '0;
      wb_we  <= 1'b0;
    end else if (!hold) begin
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (capture) begin
        ex_rs1 <= id_use_rs1_i ? id_rs1_i : '0;
        ex_rs2 <= id_use_rs2_i ? id_rs2_i : '0;
        ex_rd  <= id_rd_i;
        ex_we  <= id_regwrite_i;
        ex_ld  <= id_memread_i;
      end else begin
        ex_rs1 <= '0;
        ex_rs2 <= '0;
        ex_rd  <= '0;
        ex_we  <= 1'b0;
        ex_ld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy_i)           state_d = HOLD;
        else if (lu && !flush_i)  state_d = LU_STALL;
      end
      LU_STALL: state_d = mem_busy_i ? HOLD : RUN;
      HOLD:     if (!mem_busy_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

`ifdef FWD_HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_lu_stall_o <= '0;
      perf_fwd_o      <= '0;
      perf_hold_o     <= '0;
    end else begin
      if (stall) perf_lu_stall_o <= sat_inc(perf_lu_stall_o);
      if (((fwd_a_o != 2'b00) || (fwd_b_o != 2'b00)) && !hold) perf_fwd_o <= sat_inc(perf_fwd_o);
      if (hold) perf_hold_o <= sat_inc(perf_hold_o);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl: a per-cycle table of ID inputs and
// expected controls, followed by reset-during-stall and reset-during-hold sequences.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, flush, mem_busy;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, bubble, hold;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_fwd, perf_hold;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .NUM_REGS(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .flush_i       (flush),
    .mem_busy_i    (mem_busy),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .stall_o       (stall),
    .bubble_o      (bubble),
    .hold_o        (hold)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .perf_lu_stall_o (perf_lu),
    .perf_fwd_o      (perf_fwd),
    .perf_hold_o     (perf_hold)
`endif
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, ld, fl, bz;
    logic [1:0] ea, eb;
    logic       es, eh;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic rw, logic ld, logic fl, logic bz,
                              logic [1:0] ea, logic [1:0] eb, logic es, logic eh);
    vec_t r;
    r.v = v;  r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.rd = rd; r.rw = rw; r.ld = ld; r.fl = fl; r.bz = bz;
    r.ea = ea; r.eb = eb; r.es = es; r.eh = eh;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.v;   id_rs1 = r.rs1; id_rs2 = r.rs2;
    id_use_rs1 = r.u1; id_use_rs2 = r.u2;
    id_rd = r.rd; id_regwrite = r.rw; id_memread = r.ld;
    flush = r.fl; mem_busy = r.bz;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string tag, input vec_t r);
    chk({tag, " fwd_a"},  32'(fwd_a),  32'(r.ea));
    chk({tag, " fwd_b"},  32'(fwd_b),  32'(r.eb));
    chk({tag, " stall"},  32'(stall),  32'(r.es));
    chk({tag, " bubble"}, 32'(bubble), 32'(r.es));
    chk({tag, " hold"},   32'(hold),   32'(r.eh));
  endtask

  initial begin
    vec_t nop;
    nop = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);

    // MEM forward: add x5 ; sub x6,x5,x1
    tbl.push_back(nop);
    tbl.push_back(mk(1,1,2,1,1,5,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,5,1,1,1,6,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 2,0,0,0));
    tbl.push_back(nop);
    tbl.push_back(nop);
    // WB forward, then two writers of x7: newest (MEM) wins
    tbl.push_back(mk(1,0,0,0,0,7,1,0,0,0, 0,0,0,0));
    tbl.push_back(nop);
    tbl.push_back(mk(1,7,0,1,0,8,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,7,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,7,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,7,7,1,1,9,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 2,2,0,0));
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Load-use: lw x3 ; add x4,x3,x3
    tbl.push_back(mk(1,2,0,1,0,3,1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,3,3,1,1,4,1,0,0,0, 0,0,1,0));
    tbl.push_back(mk(1,3,3,1,1,4,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0));
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Load to x0 followed by reader of x0: no stall, no forward
    tbl.push_back(mk(1,1,0,1,0,0,1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,1,1,4,1,0,0,0, 0,0,0,0));
    tbl.push_back(nop);
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Load-use coinciding with flush: no stall, EX emptied
    tbl.push_back(mk(1,2,0,1,0,3,1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,3,3,1,1,4,1,0,1,0, 0,0,0,0));
    tbl.push_back(nop);
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Memory busy for 3 cycles during a MEM forward
    tbl.push_back(mk(1,1,2,1,1,5,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,5,1,1,1,6,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 2,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 2,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 2,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 2,0,0,0));
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Load-use masked by hold, then stalls once memory is ready
    tbl.push_back(mk(1,0,0,0,0,3,1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,3,0,1,0,4,1,0,0,1, 0,0,0,1));
    tbl.push_back(mk(1,3,0,1,0,4,1,0,0,0, 0,0,1,0));
    tbl.push_back(mk(1,3,0,1,0,4,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tbl.push_back(nop);
    tbl.push_back(nop);
    // Load followed by store using it as store data (rs2)
    tbl.push_back(mk(1,0,0,0,0,9,1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,2,9,1,1,0,0,0,0,0, 0,0,1,0));
    tbl.push_back(mk(1,2,9,1,1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(nop);

    rst = 1'b1;
    drive(nop);
    tick;
    tick;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #4;
      check_row($sformatf("row%0d", i), tbl[i]);
      tick;
    end

`ifdef FWD_HAZARD_PERF_EN
    chk("perf_lu_stall", perf_lu,   32'd3);
    chk("perf_fwd",      perf_fwd,  32'd7);
    chk("perf_hold",     perf_hold, 32'd4);
`endif

    // Reset while in LU_STALL
    drive(nop);
    tick; tick; tick;
    drive(mk(1,0,0,0,0,3,1,1,0,0, 0,0,0,0));
    tick;
    drive(mk(1,3,0,1,0,4,1,0,0,0, 0,0,0,0));
    #4;
    chk("rst_stall pre stall", 32'(stall), 32'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #4;
    check_row("rst_stall post", mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
`ifdef FWD_HAZARD_PERF_EN
    chk("rst perf_lu_stall", perf_lu,   32'd0);
    chk("rst perf_fwd",      perf_fwd,  32'd0);
    chk("rst perf_hold",     perf_hold, 32'd0);
`endif
    tick;

    // Reset while held with a live MEM forward
    drive(mk(1,1,2,1,1,5,1,0,0,0, 0,0,0,0));
    tick;
    drive(mk(1,5,1,1,1,6,1,0,0,0, 0,0,0,0));
    tick;
    drive(mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0));
    #4;
    chk("rst_hold pre fwd_a", 32'(fwd_a), 32'd2);
    chk("rst_hold pre hold",  32'(hold),  32'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(nop);
    #4;
    check_row("rst_hold post", mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Controller that sequences the two EX-stage operand forwarding muxes (A and B) of the 5-stage RISC-V pipeline.
- Keeps its own shadow scoreboard of destination register and write-enable info for the EX, MEM and WB stages, and from it drives the 2-bit mux selects.
- Detects load-use hazards and raises stall/bubble, and freezes the scoreboard while data memory is busy.
- Sits beside the ID/EX pipeline register; consumes decode info from ID and produces control for the PC, IF/ID, ID/EX and the forwarding muxes.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, architectural register count; index 0 is hard-wired zero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_i  in  REG_AW  ID source 1
- id_rs2_i  in  REG_AW  ID source 2
- id_use_rs1_i  in  1  instruction reads rs1
- id_use_rs2_i  in  1  instruction reads rs2
- id_rd_i  in  REG_AW  ID destination
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  taken branch/jump; kill the ID instruction
- mem_busy_i  in  1  data memory not ready; hold the whole pipeline
- fwd_a_o  out  2  select for operand-A mux
- fwd_b_o  out  2  select for operand-B mux
- stall_o  out  1  freeze PC and IF/ID
- bubble_o  out  1  zero the control fields entering ID/EX
- hold_o  out  1  freeze all pipeline registers

Behaviour:
- Clocking and reset: single clock clk_i; rst_i is synchronous, active-high.
- Select encoding (fixed):
  - 00 = register-file value.
  - 01 = WB-stage write data.
  - 10 = MEM-stage ALU result.
  - 11 is never driven.
- Scoreboard registers:
  - ex_{rs1,rs2,rd,we,ld}
  - mem_{rd,we}
  - wb_{rd,we}
- Reset: all scoreboard fields clear to 0. Outputs are then fwd_a_o = fwd_b_o = 00 and stall_o = bubble_o = hold_o = 0.
- Advance, when hold_o = 0:
  - wb <= mem
  - mem <= ex
  - ex <= ID fields if id_valid_i & !flush_i & !bubble_o, else all zero (a bubble)
  - ex_rs* captured only when the matching id_use_rs* is 1, else 0
- Hold: hold_o = mem_busy_i, combinational. When hold_o = 1, nothing advances and stall_o/bubble_o are forced to 0.
- Forwarding (combinational from scoreboard, zero latency relative to EX):
  - fwd_a_o = 10 if mem_we & mem_rd != 0 & mem_rd == ex_rs1.
  - Otherwise 01 if wb_we & wb_rd != 0 & wb_rd == ex_rs1.
  - Otherwise 00.
  - MEM has priority over WB.
  - fwd_b_o is the same rule using ex_rs2.
- Load-use hazard:
  - lu = ex_ld & ex_we & ex_rd != 0 & id_valid_i & ((id_use_rs1_i & id_rs1_i == ex_rd) | (id_use_rs2_i & id_rs2_i == ex_rd)).
  - When lu & !hold_o & !flush_i: stall_o = bubble_o = 1 for exactly one cycle.
  - The next cycle the load is in MEM, so lu clears.
- FSM, states RUN / LU_STALL / HOLD:
  - RUN -> LU_STALL on lu.
  - RUN -> HOLD on mem_busy_i.
  - LU_STALL -> RUN unconditionally, or -> HOLD if mem_busy_i.
  - HOLD -> RUN when mem_busy_i drops.
  - In HOLD, forward selects remain valid (scoreboard frozen).
- Boundary conditions:
  - flush_i together with lu: flush wins, no stall.
  - rd = x0 never forwards and never stalls.
  - A load followed by a dependent store-data use stalls exactly as any other use.
  - rst_i mid-stall or mid-hold returns to RUN with the scoreboard cleared on the next edge.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: adds three 32-bit outputs.
  - perf_lu_stall_o: counts lu-stall cycles.
  - perf_fwd_o: counts cycles with any non-00 select while not held.
  - perf_hold_o: counts hold cycles.
  - All three reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package fwd_pkg:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - REG_ZERO constant.
  - FSM state typedef.
- One natural sub-module, fwd_sel_unit: the combinational priority compare for a single operand. Instantiated twice (A, B).

Test Plan:
- Forward from MEM: add x5 then sub x6,x5,x1 back-to-back -> when sub is in EX, fwd_a_o = 10, fwd_b_o = 00.
- Forward from WB and priority: write x7, nop, read x7 -> fwd = 01. Write x7 twice consecutively, then read -> fwd = 10 (newest wins).
- Load-use: lw x3 followed by add x4,x3,x3 -> stall_o = bubble_o = 1 for 1 cycle, then fwd_a_o = fwd_b_o = 01.
- x0 and flush:
  - rd = 0 load followed by a dependent reader -> no stall, fwd = 00.
  - lu together with flush_i = 1 -> stall_o = 0, ex cleared.
- Hold: mem_busy_i high for 3 cycles during a MEM-forward -> hold_o = 1 for 3 cycles, fwd_a_o stays 10, scoreboard unchanged. Resumes on release.
- Reset mid-LU_STALL: assert rst_i -> next cycle all outputs 0, state RUN. With FWD_HAZARD_PERF_EN defined, counters read 0.
